mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single data-memory port (MEM_ADDR/MEM_IN/MEM_OUT/MEM_CTRL) between two requesters.
//  Port A is the CPU load/store path. Port B is the host loader/debug path.
//  Round-robin arbitration, one transaction at a time.
//  Each transaction follows a req/gnt/done handshake. Memory read latency is fixed by a parameter.
// PARAMETERS
//  WIDTH     32  data path width
//  ADDRSIZE  12  memory address width
//  RD_LAT    1   cycles from address issue to valid MEM_IN; legal range 1..4
// PORTS
//  clk       in   1         clock; all logic on rising edge
//  rst       in   1         synchronous, active-high reset
//  a_req     in   1         port A request; level, sampled only in IDLE
//  a_we      in   1         port A: 1=write, 0=read
//  a_addr    in   ADDRSIZE  port A address
//  a_wdata   in   WIDTH     port A write data
//  a_gnt     out  1         port A request accepted (1-cycle pulse)
//  a_done    out  1         port A transaction complete (1-cycle pulse)
//  a_rdata   out  WIDTH     port A read data; valid while a_done=1, held after
//  b_*       same set as a_*, for port B
//  MEM_ADDR  out  ADDRSIZE  memory address
//  MEM_OUT   out  WIDTH     memory write data
//  MEM_CTRL  out  1         0=read, 1=write
//  MEM_IN    in   WIDTH     memory read data
//  busy      out  1         1 in any state other than IDLE
//  owner     out  1         0=A, 1=B; current or last granted port
// BEHAVIOUR
//  Reset (clk edge with rst=1): all outputs 0, FSM=IDLE, rr_last=B (A wins first tie).
//  Reset is honoured in every state. An in-flight transaction is discarded: no done pulse, MEM_CTRL=0.
//  Requests are sampled only in IDLE.
//  FSM states: IDLE -> ISSUE -> (WAIT if read) -> RESP -> IDLE.
//  IDLE
//   - Only one req set: pick that port.
//   - Both set: pick the port != rr_last.
//   - On pick: latch we/addr/wdata, set owner, rr_last=pick, go to ISSUE.
//   - No req: stay in IDLE; outputs hold.
//  ISSUE (1 cycle)
//   - gnt_owner=1.
//   - MEM_ADDR=latched addr, MEM_OUT=latched wdata, MEM_CTRL=latched we.
//   - Next state: write -> RESP; read -> WAIT with lat_cnt=RD_LAT-1.
//  WAIT (RD_LAT cycles)
//   - MEM_ADDR held, MEM_CTRL=0.
//   - lat_cnt decrements each cycle.
//   - At lat_cnt==0: capture MEM_IN into rdata_owner, go to RESP.
//  RESP (1 cycle)
//   - done_owner=1 and rdata_owner is stable; next state IDLE.
//   - On a write, rdata is unchanged.
//  Signal rules
//   - MEM_CTRL=1 only in the ISSUE cycle of a write, so exactly one write strobe per write.
//   - MEM_ADDR/MEM_OUT hold their last values outside ISSUE/WAIT (no glitch to 0).
//   - gnt and done are never high for both ports in the same cycle.
//   - The requester may change addr/wdata/we or drop req any cycle after gnt.
//   - Holding req through done requests another transaction; it is arbitrated in the next IDLE cycle.
//   - req dropped before being sampled in IDLE: no transaction, no gnt.
//  Timing
//   - Latency from req seen in IDLE: read = 3+RD_LAT cycles, write = 3 cycles (IDLE+ISSUE+RESP).
//   - Fairness: with A and B both held high, grants alternate A,B,A,B...
//   - No port waits longer than one full transaction of the other port.
//   - lat_cnt is 2 bits wide; RD_LAT outside 1..4 is unsupported.
// TESTING
//  1. Reset, then a_req=1, a_we=0, a_addr=12'h010, mem[16]=32'hDEADBEEF, RD_LAT=1
//     -> a_gnt at cycle 2, MEM_ADDR=12'h010, a_done at cycle 4 with a_rdata=32'hDEADBEEF.
//  2. b_req=1, b_we=1, b_addr=12'h0FF, b_wdata=32'h12345678
//     -> MEM_CTRL=1 exactly one cycle with MEM_ADDR=12'h0FF/MEM_OUT=32'h12345678; b_done next cycle; mem[255] updated.
//  3. a_req and b_req held high, 6 reads
//     -> grant order A,B,A,B,A,B; no gnt/done overlap.
//  4. RD_LAT=3, port A read
//     -> MEM_ADDR stable for 4 cycles; a_done 6 cycles after req sampled; data captured from MEM_IN at the 3rd WAIT cycle.
//  5. rst=1 asserted during WAIT
//     -> next edge: busy=0, MEM_CTRL=0, no a_done; a following B request is granted normally.
//  6. a_req pulsed 1 cycle while FSM busy with B
//     -> ignored; no a_gnt.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter for the single data-memory port.
// Port A is the CPU load/store path; port B is the host loader/debug path.
module mem_port_arbiter #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned ADDRSIZE = 12,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_req,
  input  logic                a_we,
  input  logic [ADDRSIZE-1:0] a_addr,
  input  logic [WIDTH-1:0]    a_wdata,
  output logic                a_gnt,
  output logic                a_done,
  output logic [WIDTH-1:0]    a_rdata,
  input  logic                b_req,
  input  logic                b_we,
  input  logic [ADDRSIZE-1:0] b_addr,
  input  logic [WIDTH-1:0]    b_wdata,
  output logic                b_gnt,
  output logic                b_done,
  output logic [WIDTH-1:0]    b_rdata,
  output logic [ADDRSIZE-1:0] MEM_ADDR,
  output logic [WIDTH-1:0]    MEM_OUT,
  output logic                MEM_CTRL,
  input  logic [WIDTH-1:0]    MEM_IN,
  output logic                busy,
  output logic                owner
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

  state_t              r_state;
  state_t              w_next;
  logic                r_owner;
  logic                r_rr_last;
  logic                r_we;
  logic [ADDRSIZE-1:0] r_addr;
  logic [WIDTH-1:0]    r_wdata;
  logic [WIDTH-1:0]    r_a_rdata;
  logic [WIDTH-1:0]    r_b_rdata;
  logic [1:0]          r_lat_cnt;
  logic                w_pick_valid;
  logic                w_pick;

  // Tie goes to the port that was not granted last (0=A, 1=B).
  always_comb begin
    w_pick_valid = a_req | b_req;
    if (a_req && b_req) begin
      w_pick = ~r_rr_last;
    end else begin
      w_pick = b_req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_pick_valid) w_next = S_ISSUE;
      S_ISSUE: w_next = r_we ? S_RESP : S_WAIT;
      S_WAIT:  if (r_lat_cnt == '0) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    a_gnt  = 1'b0;
    b_gnt  = 1'b0;
    a_done = 1'b0;
    b_done = 1'b0;
    if (r_state == S_ISSUE) begin
      a_gnt = ~r_owner;
      b_gnt = r_owner;
    end
    if (r_state == S_RESP) begin
      a_done = ~r_owner;
      b_done = r_owner;
    end
  end

  // Address/data registers only change on a pick, so the memory bus holds its
  // last values outside ISSUE/WAIT instead of returning to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner   <= 1'b0;
      r_rr_last <= 1'b1;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_a_rdata <= '0;
      r_b_rdata <= '0;
      r_lat_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick_valid) begin
            r_owner   <= w_pick;
            r_rr_last <= w_pick;
            r_we      <= w_pick ? b_we : a_we;
            r_addr    <= w_pick ? b_addr : a_addr;
            r_wdata   <= w_pick ? b_wdata : a_wdata;
          end
        end
        S_ISSUE: r_lat_cnt <= LAT_INIT;
        S_WAIT: begin
          if (r_lat_cnt == '0) begin
            if (r_owner) begin
              r_b_rdata <= MEM_IN;
            end else begin
              r_a_rdata <= MEM_IN;
            end
          end else begin
            r_lat_cnt <= r_lat_cnt - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    MEM_ADDR = r_addr;
    MEM_OUT  = r_wdata;
    MEM_CTRL = (r_state == S_ISSUE) && r_we;
    busy     = (r_state != S_IDLE);
    owner    = r_owner;
    a_rdata  = r_a_rdata;
    b_rdata  = r_b_rdata;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at RD_LAT=1, one at RD_LAT=3,
// each attached to a small latency-accurate memory model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Instance 0 (RD_LAT=1)
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [11:0] a_addr = '0, b_addr = '0;
  logic [31:0] a_wdata = '0, b_wdata = '0;
  logic        a_gnt, a_done, b_gnt, b_done;
  logic [31:0] a_rdata, b_rdata;
  logic [11:0] m0_addr;
  logic [31:0] m0_out, m0_in;
  logic        m0_ctrl, busy0, owner0;

  // Instance 1 (RD_LAT=3)
  logic        p_a_req = 1'b0, p_a_we = 1'b0, p_b_req = 1'b0, p_b_we = 1'b0;
  logic [11:0] p_a_addr = '0, p_b_addr = '0;
  logic [31:0] p_a_wdata = '0, p_b_wdata = '0;
  logic        p_a_gnt, p_a_done, p_b_gnt, p_b_done;
  logic [31:0] p_a_rdata, p_b_rdata;
  logic [11:0] m1_addr;
  logic [31:0] m1_out, m1_in;
  logic        m1_ctrl, busy1, owner1;

  mem_port_arbiter #(.WIDTH(32), .ADDRSIZE(12), .RD_LAT(1)) u_dut0 (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata),
    .MEM_ADDR(m0_addr), .MEM_OUT(m0_out), .MEM_CTRL(m0_ctrl), .MEM_IN(m0_in),
    .busy(busy0), .owner(owner0)
  );

  mem_port_arbiter #(.WIDTH(32), .ADDRSIZE(12), .RD_LAT(3)) u_dut1 (
    .clk(clk), .rst(rst),
    .a_req(p_a_req), .a_we(p_a_we), .a_addr(p_a_addr), .a_wdata(p_a_wdata),
    .a_gnt(p_a_gnt), .a_done(p_a_done), .a_rdata(p_a_rdata),
    .b_req(p_b_req), .b_we(p_b_we), .b_addr(p_b_addr), .b_wdata(p_b_wdata),
    .b_gnt(p_b_gnt), .b_done(p_b_done), .b_rdata(p_b_rdata),
    .MEM_ADDR(m1_addr), .MEM_OUT(m1_out), .MEM_CTRL(m1_ctrl), .MEM_IN(m1_in),
    .busy(busy1), .owner(owner1)
  );

  // Memory models: read data is only valid RD_LAT cycles after a read issue,
  // otherwise a poison pattern is driven so early/late capture is visible.
  logic        ld_en = 1'b0;
  logic [11:0] ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic [31:0] mem0 [0:4095];
  logic [31:0] mem1 [0:4095];
  logic        v0 = 1'b0;
  logic [11:0] q0 = '0;
  logic [2:0]  v1 = '0;
  logic [11:0] q1 [0:2];

  always @(posedge clk) begin
    if (ld_en) begin
      mem0[ld_addr] <= ld_data;
      mem1[ld_addr] <= ld_data;
    end
    if (m0_ctrl) mem0[m0_addr] <= m0_out;
    if (m1_ctrl) mem1[m1_addr] <= m1_out;
    v0    <= (a_gnt | b_gnt) & ~m0_ctrl;
    q0    <= m0_addr;
    v1    <= {v1[1:0], (p_a_gnt | p_b_gnt) & ~m1_ctrl};
    q1[0] <= m1_addr;
    q1[1] <= q1[0];
    q1[2] <= q1[1];
  end

  assign m0_in = v0 ? mem0[q0] : 32'hBAD0BAD0;
  assign m1_in = v1[2] ? mem1[q1[2]] : 32'hBAD0BAD0;

  int unsigned n_strobe0 = 0, n_overlap0 = 0, n_agnt0 = 0;
  always @(negedge clk) begin
    if (m0_ctrl) n_strobe0 <= n_strobe0 + 1;
    if ((a_gnt && b_gnt) || (a_done && b_done)) n_overlap0 <= n_overlap0 + 1;
    if (a_gnt) n_agnt0 <= n_agnt0 + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [11:0] addr, input logic [31:0] data);
    ld_en = 1'b1; ld_addr = addr; ld_data = data;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if ({a_gnt, a_done, b_gnt, b_done, m0_ctrl, busy0, owner0} !== 7'b0) begin n_fail++; $display("FAIL reset_ctl0: got %b want 0000000", {a_gnt, a_done, b_gnt, b_done, m0_ctrl, busy0, owner0}); end
    n_cmp++; if (m0_addr !== 12'h000) begin n_fail++; $display("FAIL reset_addr0: got %h want 000", m0_addr); end
    n_cmp++; if (m0_out !== 32'h0) begin n_fail++; $display("FAIL reset_out0: got %h want 0", m0_out); end
    n_cmp++; if ({a_rdata, b_rdata} !== 64'h0) begin n_fail++; $display("FAIL reset_rdata0: got %h want 0", {a_rdata, b_rdata}); end
    n_cmp++; if ({p_a_gnt, p_a_done, busy1, m1_ctrl} !== 4'b0) begin n_fail++; $display("FAIL reset_ctl1: got %b want 0000", {p_a_gnt, p_a_done, busy1, m1_ctrl}); end
    rst = 1'b0;
  endtask

  task automatic test_read_single();
    a_req = 1'b1; a_we = 1'b0; a_addr = 12'h010;
    tick();
    n_cmp++; if ({a_gnt, b_gnt, m0_ctrl, busy0, owner0} !== 5'b10010) begin n_fail++; $display("FAIL rd_issue_ctl: got %b want 10010", {a_gnt, b_gnt, m0_ctrl, busy0, owner0}); end
    n_cmp++; if (m0_addr !== 12'h010) begin n_fail++; $display("FAIL rd_issue_addr: got %h want 010", m0_addr); end
    a_req = 1'b0; a_addr = 12'h123;
    tick();
    n_cmp++; if ({a_gnt, a_done, m0_ctrl} !== 3'b000) begin n_fail++; $display("FAIL rd_wait_ctl: got %b want 000", {a_gnt, a_done, m0_ctrl}); end
    n_cmp++; if (m0_addr !== 12'h010) begin n_fail++; $display("FAIL rd_wait_addr: got %h want 010", m0_addr); end
    tick();
    n_cmp++; if ({a_done, b_done} !== 2'b10) begin n_fail++; $display("FAIL rd_done: got %b want 10", {a_done, b_done}); end
    n_cmp++; if (a_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h want deadbeef", a_rdata); end
    tick();
    n_cmp++; if ({a_done, busy0} !== 2'b00) begin n_fail++; $display("FAIL rd_idle: got %b want 00", {a_done, busy0}); end
    n_cmp++; if ({a_rdata, m0_addr} !== {32'hDEADBEEF, 12'h010}) begin n_fail++; $display("FAIL rd_hold: got %h want deadbeef010", {a_rdata, m0_addr}); end
  endtask

  task automatic test_write();
    int unsigned s0;
    s0 = n_strobe0;
    b_req = 1'b1; b_we = 1'b1; b_addr = 12'h0FF; b_wdata = 32'h12345678;
    tick();
    n_cmp++; if ({b_gnt, a_gnt, m0_ctrl, owner0} !== 4'b1011) begin n_fail++; $display("FAIL wr_issue_ctl: got %b want 1011", {b_gnt, a_gnt, m0_ctrl, owner0}); end
    n_cmp++; if ({m0_addr, m0_out} !== {12'h0FF, 32'h12345678}) begin n_fail++; $display("FAIL wr_issue_bus: got %h want 0ff12345678", {m0_addr, m0_out}); end
    b_req = 1'b0; b_wdata = 32'h0;
    tick();
    n_cmp++; if ({b_done, m0_ctrl, busy0} !== 3'b101) begin n_fail++; $display("FAIL wr_resp_ctl: got %b want 101", {b_done, m0_ctrl, busy0}); end
    n_cmp++; if ({m0_out, b_rdata} !== {32'h12345678, 32'h0}) begin n_fail++; $display("FAIL wr_resp_data: got %h want 1234567800000000", {m0_out, b_rdata}); end
    tick();
    b_we = 1'b0;
    n_cmp++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL wr_idle: got %b want 0", busy0); end
    n_cmp++; if (mem0[255] !== 32'h12345678) begin n_fail++; $display("FAIL wr_mem: got %h want 12345678", mem0[255]); end
    n_cmp++; if (n_strobe0 - s0 !== 1) begin n_fail++; $display("FAIL wr_strobes: got %0d want 1", n_strobe0 - s0); end
  endtask

  task automatic test_round_robin();
    int unsigned o0;
    logic        exp_b;
    o0 = n_overlap0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 12'h020;
    b_req = 1'b1; b_we = 1'b0; b_addr = 12'h030;
    for (int k = 0; k < 6; k++) begin
      exp_b = (k % 2) == 1;
      tick();
      n_cmp++; if ({a_gnt, b_gnt} !== {~exp_b, exp_b}) begin n_fail++; $display("FAIL rr_gnt%0d: got %b want %b", k, {a_gnt, b_gnt}, {~exp_b, exp_b}); end
      tick();
      tick();
      n_cmp++; if ({a_done, b_done} !== {~exp_b, exp_b}) begin n_fail++; $display("FAIL rr_done%0d: got %b want %b", k, {a_done, b_done}, {~exp_b, exp_b}); end
      n_cmp++; if ((exp_b ? b_rdata : a_rdata) !== (exp_b ? 32'hBBBB0001 : 32'hAAAA0001)) begin n_fail++; $display("FAIL rr_data%0d: got %h want %h", k, exp_b ? b_rdata : a_rdata, exp_b ? 32'hBBBB0001 : 32'hAAAA0001); end
      if (k == 5) begin
        a_req = 1'b0; b_req = 1'b0;
      end
      tick();
    end
    n_cmp++; if (n_overlap0 - o0 !== 0) begin n_fail++; $display("FAIL rr_overlap: got %0d want 0", n_overlap0 - o0); end
    n_cmp++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL rr_idle: got %b want 0", busy0); end
  endtask

  task automatic test_rd_lat3();
    p_a_req = 1'b1; p_a_we = 1'b0; p_a_addr = 12'h040;
    tick();
    n_cmp++; if ({p_a_gnt, m1_addr} !== {1'b1, 12'h040}) begin n_fail++; $display("FAIL lat3_issue: got %h want 1040", {p_a_gnt, m1_addr}); end
    p_a_req = 1'b0; p_a_addr = 12'h7FF;
    for (int w = 0; w < 3; w++) begin
      tick();
      n_cmp++; if ({p_a_done, busy1, m1_addr} !== {2'b01, 12'h040}) begin n_fail++; $display("FAIL lat3_wait%0d: got %h want 1040", w, {p_a_done, busy1, m1_addr}); end
    end
    tick();
    n_cmp++; if (p_a_done !== 1'b1) begin n_fail++; $display("FAIL lat3_done: got %b want 1", p_a_done); end
    n_cmp++; if (p_a_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL lat3_data: got %h want cafef00d", p_a_rdata); end
    tick();
    n_cmp++; if ({p_a_done, busy1} !== 2'b00) begin n_fail++; $display("FAIL lat3_idle: got %b want 00", {p_a_done, busy1}); end
  endtask

  task automatic test_reset_in_wait();
    a_req = 1'b1; a_we = 1'b0; a_addr = 12'h020;
    tick();
    n_cmp++; if (a_gnt !== 1'b1) begin n_fail++; $display("FAIL rstw_gnt: got %b want 1", a_gnt); end
    a_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    n_cmp++; if ({busy0, m0_ctrl, a_done, a_gnt} !== 4'b0000) begin n_fail++; $display("FAIL rstw_ctl: got %b want 0000", {busy0, m0_ctrl, a_done, a_gnt}); end
    n_cmp++; if ({m0_addr, a_rdata} !== 44'h0) begin n_fail++; $display("FAIL rstw_regs: got %h want 0", {m0_addr, a_rdata}); end
    rst = 1'b0;
    tick();
    tick();
    n_cmp++; if ({a_done, busy0} !== 2'b00) begin n_fail++; $display("FAIL rstw_quiet: got %b want 00", {a_done, busy0}); end
    b_req = 1'b1; b_we = 1'b0; b_addr = 12'h030;
    tick();
    n_cmp++; if ({a_gnt, b_gnt} !== 2'b01) begin n_fail++; $display("FAIL rstw_bgnt: got %b want 01", {a_gnt, b_gnt}); end
    b_req = 1'b0;
    tick();
    tick();
    n_cmp++; if ({a_done, b_done, b_rdata} !== {2'b01, 32'hBBBB0001}) begin n_fail++; $display("FAIL rstw_bdone: got %h want 1bbbb0001", {a_done, b_done, b_rdata}); end
    tick();
  endtask

  task automatic test_ignored_pulse();
    int unsigned g0;
    g0 = n_agnt0;
    b_req = 1'b1; b_we = 1'b1; b_addr = 12'h050; b_wdata = 32'h55AA55AA;
    a_we = 1'b0; a_addr = 12'h010;
    tick();
    n_cmp++; if (b_gnt !== 1'b1) begin n_fail++; $display("FAIL pulse_bgnt: got %b want 1", b_gnt); end
    b_req = 1'b0; a_req = 1'b1;
    tick();
    n_cmp++; if (b_done !== 1'b1) begin n_fail++; $display("FAIL pulse_bdone: got %b want 1", b_done); end
    a_req = 1'b0;
    tick();
    tick();
    n_cmp++; if ({a_gnt, busy0} !== 2'b00) begin n_fail++; $display("FAIL pulse_idle: got %b want 00", {a_gnt, busy0}); end
    n_cmp++; if (n_agnt0 - g0 !== 0) begin n_fail++; $display("FAIL pulse_agnt: got %0d want 0", n_agnt0 - g0); end
    b_we = 1'b0;
  endtask

  initial begin
    tick();
    preload(12'h010, 32'hDEADBEEF);
    preload(12'h020, 32'hAAAA0001);
    preload(12'h030, 32'hBBBB0001);
    preload(12'h040, 32'hCAFEF00D);
    test_reset();
    test_read_single();
    test_write();
    test_round_robin();
    test_rd_lat3();
    test_reset_in_wait();
    test_ignored_pulse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
